// File: rtl/mips_pkg.sv
// Shared definitions for the memory port arbiter: default widths, the
// arbiter state encoding and a helper that sizes the data-streak counter.
package mips_pkg;

    localparam int ARB_ADDR_W       = 32;
    localparam int ARB_DATA_W       = 32;
    localparam int ARB_MAX_D_STREAK = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    // Counter must be able to hold the saturation value itself.
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Grant selection between the fetch and data requesters, with a bounded
// data-stage streak so fetch cannot be starved indefinitely.
module mem_arb_fairness
    import mips_pkg::*;
#(
    parameter int MAX_D_STREAK = ARB_MAX_D_STREAK
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_idle,
    input  logic if_req,
    input  logic d_req,
    input  logic if_done,
    input  logic d_done,
    output logic grant_i,
    output logic grant_d
);

    localparam int SW = streak_width(MAX_D_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak_cnt;
    logic          if_elig;
    logic          d_elig;
    logic          fetch_due;

    // A requester whose completion is pulsing this cycle is not eligible.
    always_comb begin
        if_elig   = if_req & ~if_done;
        d_elig    = d_req & ~d_done;
        fetch_due = (streak_cnt == STREAK_MAX) & if_elig;
        grant_d   = arb_idle & d_elig & ~fetch_due;
        grant_i   = arb_idle & if_elig & ~grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_cnt <= '0;
        end else if (grant_d) begin
            if (!if_req) begin
                streak_cnt <= '0;
            end else if (streak_cnt != STREAK_MAX) begin
                streak_cnt <= streak_cnt + SW'(1);
            end
        end else if (grant_i) begin
            streak_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the data stage.
// One transaction in flight; request fields are latched at grant time.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int MAX_D_STREAK = ARB_MAX_D_STREAK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t state;
    arb_state_t next_state;
    logic       grant_i;
    logic       grant_d;

    mem_arb_fairness #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_fairness (
        .clk     (clk),
        .reset   (reset),
        .arb_idle(state == ARB_IDLE),
        .if_req  (if_req),
        .d_req   (d_rd | d_wr),
        .if_done (if_done),
        .d_done  (d_done),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ARB_IDLE: begin
                if (grant_d) begin
                    next_state = ARB_SERVE_D;
                end else if (grant_i) begin
                    next_state = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I,
            ARB_SERVE_D: begin
                if (mem_ack) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops it at once.
    assign mem_req = (state != ARB_IDLE);

    // A simultaneous read and write is served as a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        mem_we    <= d_wr;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grant_i) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                ARB_SERVE_I: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end
                end
                ARB_SERVE_D: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        d_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
